// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // An all-zero word is what downstream decodes as a bubble.
    localparam int PIPE_BUBBLE_INSTR = 0;
    localparam int PIPE_BUBBLE_PC    = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n)
            count <= '0;
        else if (en && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked IF/ID-style stage register with a two-entry skid buffer and flush.
// Optional stall/flush statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 64,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count
`endif
);

    localparam logic [INSTR_W-1:0] BUB_INSTR = INSTR_W'(PIPE_BUBBLE_INSTR);
    localparam logic [PC_W-1:0]    BUB_PC    = PC_W'(PIPE_BUBBLE_PC);

    pipe_state_t        state, state_d;
    logic [INSTR_W-1:0] main_instr, main_instr_d, skid_instr, skid_instr_d;
    logic [PC_W-1:0]    main_pc, main_pc_d, skid_pc, skid_pc_d;
    logic               in_xfer, out_xfer;

    assign out_valid = (state != EMPTY);
    assign out_instr = main_instr;
    assign out_pc    = main_pc;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d      = state;
        main_instr_d = main_instr;
        main_pc_d    = main_pc;
        skid_instr_d = skid_instr;
        skid_pc_d    = skid_pc;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                end else if (in_xfer) begin
                    skid_instr_d = in_instr;
                    skid_pc_d    = in_pc;
                    state_d      = FULL;
                end else if (out_xfer) begin
                    // Draining to empty leaves a bubble on the outputs.
                    main_instr_d = BUB_INSTR;
                    main_pc_d    = BUB_PC;
                    state_d      = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_instr_d = skid_instr;
                    main_pc_d    = skid_pc;
                    skid_instr_d = BUB_INSTR;
                    skid_pc_d    = BUB_PC;
                    state_d      = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A redirect kills everything, including an entry accepted this cycle.
        if (flush) begin
            state_d      = EMPTY;
            main_instr_d = BUB_INSTR;
            main_pc_d    = BUB_PC;
            skid_instr_d = BUB_INSTR;
            skid_pc_d    = BUB_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= EMPTY;
            in_ready   <= 1'b0;
            main_instr <= BUB_INSTR;
            main_pc    <= BUB_PC;
            skid_instr <= BUB_INSTR;
            skid_pc    <= BUB_PC;
        end else begin
            state      <= state_d;
            in_ready   <= (state_d != FULL);
            main_instr <= main_instr_d;
            main_pc    <= main_pc_d;
            skid_instr <= skid_instr_d;
            skid_pc    <= skid_pc_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (reset_n),
        .en    (out_valid && !out_ready),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr_n (reset_n),
        .en    (flush),
        .count (flush_count)
    );
`else
    logic stats_unused;
    assign stats_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; statistics checks build with PIPE_STAGE_STATS_EN.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
`ifdef PIPE_STAGE_STATS_EN
    logic [3:0]  stall_count;
    logic [3:0]  flush_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.INSTR_W(32), .PC_W(64), .CNT_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_count (stall_count),
        .flush_count (flush_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares {out_valid, in_ready, out_instr, out_pc} against one expected vector.
    task automatic expect_out(input string name, input logic v, input logic r,
                              input logic [31:0] ins, input logic [63:0] pc);
        checks++;
        if ({out_valid, in_ready, out_instr, out_pc} !== {v, r, ins, pc}) begin
            errors++;
            $display("FAIL %s: got v=%b r=%b instr=%h pc=%h, want v=%b r=%b instr=%h pc=%h",
                     name, out_valid, in_ready, out_instr, out_pc, v, r, ins, pc);
        end
    endtask

    task automatic offer(input logic v, input logic [63:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_instr = v ? (32'hA000_0000 | 32'(pc)) : 32'h0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        offer(1'b0, 64'h0);
        flush = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        expect_out("reset_hold", 1'b0, 1'b0, 32'h0, 64'h0);
`ifdef PIPE_STAGE_STATS_EN
        checks++;
        if ({stall_count, flush_count} !== 8'h00) begin
            errors++;
            $display("FAIL reset_counters: got %h want 00", {stall_count, flush_count});
        end
`endif
        reset_n = 1'b1;
        step();
        expect_out("reset_release", 1'b0, 1'b1, 32'h0, 64'h0);
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        offer(1'b1, 64'h0); step();
        expect_out("stream_0", 1'b1, 1'b1, 32'hA000_0000, 64'h0);
        offer(1'b1, 64'h4); step();
        expect_out("stream_4", 1'b1, 1'b1, 32'hA000_0004, 64'h4);
        offer(1'b1, 64'h8); step();
        expect_out("stream_8", 1'b1, 1'b1, 32'hA000_0008, 64'h8);
        offer(1'b0, 64'h0); step();
        expect_out("stream_drain", 1'b0, 1'b1, 32'h0, 64'h0);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(1'b1, 64'h10); step();
        expect_out("bp_a_in", 1'b1, 1'b1, 32'hA000_0010, 64'h10);
        offer(1'b1, 64'h14); step();
        expect_out("bp_b_in_full", 1'b1, 1'b0, 32'hA000_0010, 64'h10);
        offer(1'b1, 64'h30); step();
        expect_out("bp_hold", 1'b1, 1'b0, 32'hA000_0010, 64'h10);
        offer(1'b0, 64'h0);
        out_ready = 1'b1; step();
        expect_out("bp_drain_b", 1'b1, 1'b1, 32'hA000_0014, 64'h14);
        step();
        expect_out("bp_drain_empty", 1'b0, 1'b1, 32'h0, 64'h0);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(1'b1, 64'h20); step();
        offer(1'b1, 64'h24); step();
        expect_out("flush_prefill", 1'b1, 1'b0, 32'hA000_0020, 64'h20);
        flush = 1'b1;
        offer(1'b1, 64'h18); step();
        expect_out("flush_full", 1'b0, 1'b1, 32'h0, 64'h0);
        flush = 1'b0;
        offer(1'b0, 64'h0);
        out_ready = 1'b1; step();
        expect_out("flush_no_c", 1'b0, 1'b1, 32'h0, 64'h0);
        // Flush in ONE with a live input transfer: the entry is swallowed.
        out_ready = 1'b0;
        offer(1'b1, 64'h40); step();
        flush = 1'b1;
        offer(1'b1, 64'h44); step();
        flush = 1'b0;
        offer(1'b0, 64'h0); step();
        expect_out("flush_one_discard", 1'b0, 1'b1, 32'h0, 64'h0);
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        offer(1'b1, 64'h50); step();
        expect_out("rst_mid_one", 1'b1, 1'b1, 32'hA000_0050, 64'h50);
        offer(1'b0, 64'h0);
        reset_n = 1'b0;
        flush = 1'b1;
        step();
        expect_out("rst_mid_cleared", 1'b0, 1'b0, 32'h0, 64'h0);
        flush = 1'b0;
        reset_n = 1'b1;
        step();
        expect_out("rst_mid_release", 1'b0, 1'b1, 32'h0, 64'h0);
    endtask

`ifdef PIPE_STAGE_STATS_EN
    task automatic test_stats();
        do_reset();
        out_ready = 1'b0;
        offer(1'b1, 64'h60); step();
        offer(1'b0, 64'h0);
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (stall_count !== 4'hF) begin
            errors++;
            $display("FAIL stats_stall_sat: got %0d want 15", stall_count);
        end
        flush = 1'b1;
        for (int i = 0; i < 3; i++) step();
        flush = 1'b0;
        step();
        checks++;
        if (flush_count !== 4'd3) begin
            errors++;
            $display("FAIL stats_flush: got %0d want 3", flush_count);
        end
        checks++;
        if (stall_count !== 4'hF) begin
            errors++;
            $display("FAIL stats_stall_kept: got %0d want 15", stall_count);
        end
        reset_n = 1'b0;
        step();
        checks++;
        if ({stall_count, flush_count} !== 8'h00) begin
            errors++;
            $display("FAIL stats_reset: got %h want 00", {stall_count, flush_count});
        end
        reset_n = 1'b1;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_midstream();
`ifdef PIPE_STAGE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
